// File: rtl/common_pkg.sv
// Shared NoC parameters and small types used across the switch datapath.
package common_pkg;

  localparam int unsigned DEFAULT_D_W = 8;

  typedef logic noc_arb2_sel_t;

endpackage

// File: rtl/mux.sv
// Generic N:1 combinational multiplexer over a packed array of W-bit words.
module mux #(
  parameter int unsigned N = 2,
  parameter int unsigned W = common_pkg::DEFAULT_D_W
) (
  input  logic [N-1:0][W-1:0]                    i,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]   s,
  output logic [W-1:0]                           o
);

  always_comb o = i[s];

endmodule

// File: rtl/noc_arb2_stage.sv
// Two-input round-robin arbiter with registered output toward a NoC link.
// Define NOC_ARB2_SKID_EN to add a one-entry skid register that cuts o_ready -> i_ready.
module noc_arb2_stage
  import common_pkg::*;
#(
  parameter int unsigned W = DEFAULT_D_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0][W-1:0] i_data,
  input  logic [1:0]        i_valid,
  output logic [1:0]        i_ready,
  output logic [W-1:0]      o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output noc_arb2_sel_t     o_sel
);

  noc_arb2_sel_t  pri;
  noc_arb2_sel_t  grant;
  logic           any_valid;
  logic           accept;
  logic           xfer;
  logic [W-1:0]   mux_o;

  // Lone requester wins outright; contention is resolved by pri.
  always_comb begin
    any_valid = |i_valid;
    grant     = (&i_valid) ? pri : i_valid[1];
    i_ready   = 2'b00;
    if (any_valid) i_ready[grant] = accept;
  end

  assign xfer = any_valid & accept;

  mux #(.N(2), .W(W)) u_mux (
    .i (i_data),
    .s (grant),
    .o (mux_o)
  );

`ifdef NOC_ARB2_SKID_EN
  logic           skid_valid;
  logic [W-1:0]   skid_data;
  noc_arb2_sel_t  skid_sel;

  assign accept = ~skid_valid;

  // Skid only fills while the main register is stalled; it refills main on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_sel      <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= 1'b0;
      pri        <= 1'b0;
    end else begin
      if (xfer) pri <= ~grant;
      if (skid_valid) begin
        if (o_ready) begin
          o_data     <= skid_data;
          o_sel      <= skid_sel;
          skid_valid <= 1'b0;
        end
      end else if (xfer) begin
        if (~o_valid | o_ready) begin
          o_valid <= 1'b1;
          o_data  <= mux_o;
          o_sel   <= grant;
        end else begin
          skid_valid <= 1'b1;
          skid_data  <= mux_o;
          skid_sel   <= grant;
        end
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
`else
  assign accept = ~o_valid | o_ready;

  // New flit overwrites a draining one, so streaming has no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sel   <= 1'b0;
      pri     <= 1'b0;
    end else begin
      if (xfer) begin
        pri     <= ~grant;
        o_valid <= 1'b1;
        o_data  <= mux_o;
        o_sel   <= grant;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_arb2_stage.sv
// Directed and random bench for noc_arb2_stage; in-flight flits are tracked in a scoreboard queue.
module tb_noc_arb2_stage;
  import common_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic         sel;
    logic [W-1:0] data;
  } flit_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0][W-1:0] i_data;
  logic [1:0]        i_valid;
  logic [1:0]        i_ready;
  logic [W-1:0]      o_data;
  logic              o_valid;
  logic              o_ready;
  noc_arb2_sel_t     o_sel;

  noc_arb2_stage #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_sel   (o_sel)
  );

  always #5 clk = ~clk;

  flit_t        sb[$];
  logic         m_pri;
  logic         src_pend [2];
  logic [W-1:0] src_data [2];
  logic [7:0]   src_seq  [2];
  logic [W-1:0] base     [2];
  int           wait_cnt [2];
  int           n_checks;
  int           n_pass;
  int           n_xfer_obs;
  logic         alt_chk;
  logic         alt_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One cycle: sources offer flits, model predicts handshake, outputs are checked at negedge.
  task automatic step(input bit g0, input bit g1, input logic ordy);
    logic [1:0] iv;
    logic [1:0] exp_ir;
    logic [1:0] obs_x;
    logic       any;
    logic       g;
    logic       acc;
    flit_t      f;
    for (int k = 0; k < 2; k++) begin
      if (!src_pend[k] && ((k == 0) ? g0 : g1)) begin
        src_pend[k] = 1'b1;
        src_data[k] = base[k] + W'(src_seq[k]);
        src_seq[k]++;
      end
    end
    i_valid   = {src_pend[1], src_pend[0]};
    i_data[0] = src_data[0];
    i_data[1] = src_data[1];
    o_ready   = ordy;
    @(negedge clk);
    iv  = i_valid;
    any = |iv;
    g   = (iv == 2'b11) ? m_pri : iv[1];
`ifdef NOC_ARB2_SKID_EN
    acc = (sb.size() < 2);
`else
    acc = (sb.size() == 0) || ordy;
`endif
    exp_ir = 2'b00;
    if (any && acc) exp_ir[g] = 1'b1;
    check("i_ready", 32'(i_ready), 32'(exp_ir));
    check("o_valid", 32'(o_valid), 32'(sb.size() > 0));
    obs_x = i_ready & iv;
    n_xfer_obs += int'(obs_x[0]) + int'(obs_x[1]);
    for (int k = 0; k < 2; k++) begin
      if (!iv[k] || obs_x[k]) begin
        wait_cnt[k] = 0;
      end else if (obs_x[1-k]) begin
        wait_cnt[k]++;
        check("starve_bound", 32'(wait_cnt[k] > 1), 32'(0));
      end
    end
    if (sb.size() > 0) begin
      check("out_data", 32'(o_data), 32'(sb[0].data));
      check("out_sel", 32'(o_sel), 32'(sb[0].sel));
      if (ordy) begin
        f = sb.pop_front();
        if (alt_chk) begin
          check("alt_sel", 32'(o_sel), 32'(alt_exp));
          alt_exp = ~alt_exp;
        end
      end
    end
    if (any && acc) begin
      f.sel  = g;
      f.data = src_data[g];
      sb.push_back(f);
      src_pend[g] = 1'b0;
      m_pri = ~g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    m_pri       = 1'b0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
  endtask

  initial begin
    rst        = 1'b1;
    i_valid    = 2'b00;
    i_data     = '0;
    o_ready    = 1'b0;
    m_pri      = 1'b0;
    n_checks   = 0;
    n_pass     = 0;
    n_xfer_obs = 0;
    alt_chk    = 1'b0;
    alt_exp    = 1'b0;
    for (int k = 0; k < 2; k++) begin
      src_pend[k] = 1'b0;
      src_data[k] = '0;
      src_seq[k]  = 8'd0;
      wait_cnt[k] = 0;
    end
    base[0] = 8'h10;
    base[1] = 8'h20;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset then idle
    repeat (5) begin
      step(1'b0, 1'b0, 1'b0);
      check("idle_sel", 32'(o_sel), 32'(0));
    end

    // lone requester on input 1
    src_pend[1] = 1'b1;
    src_data[1] = 8'hA5;
    step(1'b0, 1'b0, 1'b1);
    check("lone_data", 32'(o_data), 32'h0000_00A5);
    check("lone_sel", 32'(o_sel), 32'(1));
    check("lone_valid", 32'(o_valid), 32'(1));
    step(1'b0, 1'b0, 1'b1);

    // continuous contention alternates 0,1,0,1 at full rate
    do_reset();
    src_seq[0] = 8'd0;
    src_seq[1] = 8'd0;
    alt_chk    = 1'b1;
    alt_exp    = 1'b0;
    n_xfer_obs = 0;
    repeat (12) step(1'b1, 1'b1, 1'b1);
    check("stream_rate", 32'(n_xfer_obs), 32'(12));
    alt_chk = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b1);

    // backpressure with both inputs requesting
    do_reset();
    n_xfer_obs = 0;
    repeat (4) step(1'b1, 1'b1, 1'b0);
`ifdef NOC_ARB2_SKID_EN
    check("bp_xfers", 32'(n_xfer_obs), 32'(2));
`else
    check("bp_xfers", 32'(n_xfer_obs), 32'(1));
`endif
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check("bp_empty", 32'(o_valid), 32'(0));

    // reset while stalled discards held flits
    repeat (3) step(1'b1, 1'b1, 1'b0);
    do_reset();
    check("rst_valid", 32'(o_valid), 32'(0));
    step(1'b1, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    check("rst_empty", 32'(o_valid), 32'(0));

    // random traffic
    repeat (10000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 3) != 0));
    repeat (8) step(1'b0, 1'b0, 1'b1);
    check("final_empty", 32'(o_valid), 32'(0));
    check("final_src_idle", 32'({src_pend[1], src_pend[0]}), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
